// File: rtl/gshare_btb_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gshare_btb_predictor                                       |
// | Description : Fetch-stage branch predictor. A gshare pattern history     |
// |               table (PC xor global history) and a direct-mapped tagged   |
// |               BTB give a same-cycle taken/target prediction. The tables  |
// |               train from EX, and EX repairs the global history on a      |
// |               mispredict.                                                |
// | Options     : define BPU_STATS_EN to add saturating 16-bit branch and    |
// |               mispredict counters (stat_branches_o, stat_mispredicts_o). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gshare_btb_predictor #(
  parameter int PC_W      = 5,  // word-address width of PC and targets
  parameter int GHR_W     = 5,  // history bits, 2 <= GHR_W <= PC_W
  parameter int CTR_W     = 2,  // PHT counter width, >= 2
  parameter int BTB_IDX_W = 3   // BTB index bits, BTB_IDX_W < PC_W
) (
  input  logic             clk_i,
  input  logic             reset_ni,        // asynchronous, active-low
  // fetch-side lookup
  input  logic             fetch_valid_i,
  input  logic [PC_W-1:0]  fetch_pc_i,
  output logic             pred_taken_o,
  output logic [PC_W-1:0]  pred_target_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  // execute-side resolution
  input  logic             upd_valid_i,
  input  logic [PC_W-1:0]  upd_pc_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_taken_i,
  input  logic [PC_W-1:0]  upd_target_i,
  input  logic             upd_mispredict_i
`ifdef BPU_STATS_EN
  ,
  output logic [15:0]      stat_branches_o,
  output logic [15:0]      stat_mispredicts_o
`endif
);

  localparam int PHT_N = 1 << GHR_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = PC_W - BTB_IDX_W;

  // Counters start weakly not-taken so a single taken outcome flips them.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN  = '0;

  // --------------------------------------------------------------------------
  // Predictor state
  // --------------------------------------------------------------------------
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CTR_W-1:0] pht_q [PHT_N];
  logic [BTB_N-1:0] btb_valid_q;
  logic [TAG_W-1:0] btb_tag_q [BTB_N];
  logic [PC_W-1:0]  btb_tgt_q [BTB_N];

  // --------------------------------------------------------------------------
  // Lookup: purely combinational from registered state, so an update in the
  // same cycle is only seen by the following lookup.
  // --------------------------------------------------------------------------
  logic [GHR_W-1:0]     w_pidx;
  logic [BTB_IDX_W-1:0] w_bidx;
  logic [TAG_W-1:0]     w_btag;
  logic [CTR_W-1:0]     w_ctr_rd;
  logic                 w_hit;

  assign w_pidx   = fetch_pc_i[GHR_W-1:0] ^ ghr_q;
  assign w_bidx   = fetch_pc_i[BTB_IDX_W-1:0];
  assign w_btag   = fetch_pc_i[PC_W-1:BTB_IDX_W];
  assign w_ctr_rd = pht_q[w_pidx];
  assign w_hit    = btb_valid_q[w_bidx] && (btb_tag_q[w_bidx] == w_btag);

  // A PC with no BTB entry is never predicted taken: there is no target.
  assign pred_taken_o  = w_hit && w_ctr_rd[CTR_W-1];
  assign pred_target_o = w_hit ? btb_tgt_q[w_bidx] : '0;
  assign pred_ghr_o    = ghr_q;

  // --------------------------------------------------------------------------
  // Update-side indexing and counter arithmetic
  // --------------------------------------------------------------------------
  logic [GHR_W-1:0]     w_uidx;
  logic [BTB_IDX_W-1:0] w_ubidx;
  logic [TAG_W-1:0]     w_utag;
  logic [CTR_W-1:0]     w_ctr_old;
  logic [CTR_W-1:0]     w_ctr_new;

  assign w_uidx    = upd_pc_i[GHR_W-1:0] ^ upd_ghr_i;
  assign w_ubidx   = upd_pc_i[BTB_IDX_W-1:0];
  assign w_utag    = upd_pc_i[PC_W-1:BTB_IDX_W];
  assign w_ctr_old = pht_q[w_uidx];

  // Saturating increment/decrement of the trained counter.
  always_comb begin
    w_ctr_new = w_ctr_old;
    if (upd_taken_i) begin
      if (w_ctr_old != CTR_MAX) w_ctr_new = w_ctr_old + CTR_W'(1);
    end else begin
      if (w_ctr_old != CTR_MIN) w_ctr_new = w_ctr_old - CTR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Global history: a mispredict repair outranks the speculative shift, since
  // the PC being fetched in that cycle is about to be flushed.
  // --------------------------------------------------------------------------
  // Select the next history value.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i && upd_mispredict_i) begin
      ghr_d = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
    end else if (fetch_valid_i && w_hit) begin
      ghr_d = {ghr_q[GHR_W-2:0], pred_taken_o};
    end
  end

  // History register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // PHT: reset every counter to weakly not-taken, train one entry per update.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else if (upd_valid_i) begin
      pht_q[w_uidx] <= w_ctr_new;
    end
  end

  // BTB valid bits: cleared on reset, set when a taken branch is installed.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      btb_valid_q <= '0;
    end else if (upd_valid_i && upd_taken_i) begin
      btb_valid_q[w_ubidx] <= 1'b1;
    end
  end

  // BTB tag/target payload; meaningless while the valid bit is clear.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i && upd_taken_i) begin
      btb_tag_q[w_ubidx] <= w_utag;
      btb_tgt_q[w_ubidx] <= upd_target_i;
    end
  end

`ifdef BPU_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating resolution statistics
  // --------------------------------------------------------------------------
  logic [15:0] stat_br_q;
  logic [15:0] stat_mis_q;

  // Count resolved branches and mispredicts, holding at all-ones.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (upd_valid_i && (stat_br_q != 16'hFFFF)) begin
        stat_br_q <= stat_br_q + 16'd1;
      end
      if (upd_valid_i && upd_mispredict_i && (stat_mis_q != 16'hFFFF)) begin
        stat_mis_q <= stat_mis_q + 16'd1;
      end
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gshare_btb_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gshare_btb_predictor                                    |
// | Description : Directed bench for gshare_btb_predictor with a reference   |
// |               model and an expectation queue.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_valid;
  logic [4:0]  fetch_pc;
  logic        pred_taken;
  logic [4:0]  pred_target;
  logic [4:0]  pred_ghr;
  logic        upd_valid;
  logic [4:0]  upd_pc;
  logic [4:0]  upd_ghr;
  logic        upd_taken;
  logic [4:0]  upd_target;
  logic        upd_mispredict;
`ifdef BPU_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  gshare_btb_predictor #(
    .PC_W(5), .GHR_W(5), .CTR_W(2), .BTB_IDX_W(3)
  ) dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .fetch_valid_i    (fetch_valid),
    .fetch_pc_i       (fetch_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .pred_ghr_o       (pred_ghr),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_ghr_i        (upd_ghr),
    .upd_taken_i      (upd_taken),
    .upd_target_i     (upd_target),
    .upd_mispredict_i (upd_mispredict)
`ifdef BPU_STATS_EN
    ,
    .stat_branches_o    (stat_branches),
    .stat_mispredicts_o (stat_mispredicts)
`endif
  );

  // Expectation scoreboard
  typedef struct {
    string      tag;
    logic       taken;
    logic [4:0] target;
    logic [4:0] ghr;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [4:0] m_ghr;
  logic [1:0] m_pht  [32];
  logic       m_bv   [8];
  logic [1:0] m_btag [8];
  logic [4:0] m_btgt [8];
  int         m_br;
  int         m_mis;

  task automatic m_reset();
    m_ghr = '0;
    for (int i = 0; i < 32; i++) m_pht[i] = 2'b01;
    for (int i = 0; i < 8; i++) begin
      m_bv[i]   = 1'b0;
      m_btag[i] = '0;
      m_btgt[i] = '0;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  function automatic logic m_hit(input logic [4:0] pc);
    return m_bv[pc[2:0]] && (m_btag[pc[2:0]] == pc[4:3]);
  endfunction

  function automatic logic m_taken(input logic [4:0] pc);
    return m_hit(pc) && m_pht[pc ^ m_ghr][1];
  endfunction

  // Advance the model by one clock edge using the inputs that were applied.
  task automatic m_clock(input logic fv, input logic [4:0] fpc, input logic uv,
                         input logic [4:0] upc, input logic [4:0] ughr,
                         input logic ut, input logic [4:0] utgt, input logic umis);
    logic [4:0] ng;
    logic [4:0] ui;
    ng = m_ghr;
    if (uv && umis)            ng = {ughr[3:0], ut};
    else if (fv && m_hit(fpc)) ng = {m_ghr[3:0], m_taken(fpc)};
    if (uv) begin
      ui = upc ^ ughr;
      if (ut) begin
        if (m_pht[ui] != 2'b11) m_pht[ui] = m_pht[ui] + 2'd1;
        m_bv[upc[2:0]]   = 1'b1;
        m_btag[upc[2:0]] = upc[4:3];
        m_btgt[upc[2:0]] = utgt;
      end else begin
        if (m_pht[ui] != 2'b00) m_pht[ui] = m_pht[ui] - 2'd1;
      end
      m_br++;
      if (umis) m_mis++;
    end
    m_ghr = ng;
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".taken"},  {15'd0, pred_taken}, {15'd0, e.taken});
      cmp({e.tag, ".target"}, {11'd0, pred_target}, {11'd0, e.target});
      cmp({e.tag, ".ghr"},    {11'd0, pred_ghr},    {11'd0, e.ghr});
    end
  endtask

  // One cycle: drive, queue the expectation (model or pinned constant),
  // sample mid-cycle, then clock DUT and model together.
  task automatic step(input string tag, input logic fv, input logic [4:0] fpc,
                      input logic uv, input logic [4:0] upc, input logic [4:0] ughr,
                      input logic ut, input logic [4:0] utgt, input logic umis,
                      input logic pin, input logic kt, input logic [4:0] ktgt,
                      input logic [4:0] kghr);
    exp_t e;
    @(negedge clk);
    fetch_valid = fv;  fetch_pc = fpc;
    upd_valid = uv;    upd_pc = upc;   upd_ghr = ughr;
    upd_taken = ut;    upd_target = utgt; upd_mispredict = umis;
    e.tag = tag;
    if (pin) begin
      e.taken = kt; e.target = ktgt; e.ghr = kghr;
    end else begin
      e.taken  = m_taken(fpc);
      e.target = m_hit(fpc) ? m_btgt[fpc[2:0]] : 5'd0;
      e.ghr    = m_ghr;
    end
    sb.push_back(e);
    #1;
    check_outputs();
    @(posedge clk);
    m_clock(fv, fpc, uv, upc, ughr, ut, utgt, umis);
  endtask

  task automatic idle_inputs();
    fetch_valid = 1'b0; fetch_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
  endtask

  task automatic push_zero(input string tag);
    exp_t e;
    e.tag = tag; e.taken = 1'b0; e.target = '0; e.ghr = '0;
    sb.push_back(e);
  endtask

  // Safety net in case the sequence stalls.
  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    m_reset();
    #3;
    push_zero("in_reset");
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Cold tables: nothing predicted taken anywhere.
    for (int i = 0; i < 32; i++) begin
      step($sformatf("cold_pc%0d", i), 1'b1, 5'(i), 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
           1'b1, 1'b0, 5'd0, 5'd0);
    end

    // First training installs BTB[4] and repairs history to 00001.
    step("train1", 1'b1, 5'd0, 1'b1, 5'd4, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
    step("hit_weak", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 5'd1);

    // Two more taken trainings saturate pht[4] at 11 (history frozen).
    step("train2", 1'b0, 5'd0, 1'b1, 5'd4, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step("train3", 1'b0, 5'd0, 1'b1, 5'd4, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    // Repair history back to zero via a not-taken mispredict at pc1.
    step("repair0", 1'b0, 5'd0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step("sat_hi", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd0);

    // pht[1] held at 00, then one taken -> 01 (not taken) with BTB[1]=7.
    step("dec_sat", 1'b0, 5'd0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step("inc_pc1", 1'b0, 5'd0, 1'b1, 5'd1, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step("repair1", 1'b0, 5'd0, 1'b1, 5'd2, 5'b10000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step("sat_lo", 1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0);

    // Repair and speculative shift in the same cycle: repair wins.
    step("race", 1'b1, 5'd4, 1'b1, 5'd2, 5'b10110, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall%0d", i), 1'b0, 5'd4, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
           1'b1, 1'b0, 5'd9, 5'b01100);
    end
    step("resume", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 5'b01100);

    // Same-cycle lookup and install of pc3: old view now, new view next cycle.
    step("same_old", 1'b1, 5'd3, 1'b1, 5'd3, 5'd24, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 5'd24);
    step("same_new", 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd24);

    // Asynchronous reset in the middle of a cycle with live traffic.
    @(negedge clk);
    fetch_valid = 1'b1; fetch_pc = 5'd3;
    upd_valid = 1'b1; upd_pc = 5'd3; upd_ghr = 5'd0;
    upd_taken = 1'b1; upd_target = 5'd5; upd_mispredict = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    push_zero("rst_async");
    check_outputs();
    m_reset();
    @(posedge clk);
    #1;
    push_zero("rst_hold");
    check_outputs();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    step("post_rst_pc4", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    step("post_rst_pc3", 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);

    // Five resolutions, two of them mispredicted; predictions from the model.
    step("u1", 1'b1, 5'd4, 1'b1, 5'd4, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step("u2", 1'b1, 5'd4, 1'b1, 5'd4, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step("u3", 1'b1, 5'd4, 1'b1, 5'd4, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step("u4", 1'b1, 5'd4, 1'b1, 5'd6, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step("u5", 1'b1, 5'd4, 1'b1, 5'd4, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step("u_after", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

`ifdef BPU_STATS_EN
    #1;
    cmp("stat_branches", stat_branches, 16'(m_br));
    cmp("stat_mispredicts", stat_mispredicts, 16'(m_mis));
    cmp("stat_branches_5", stat_branches, 16'd5);
    cmp("stat_mispredicts_2", stat_mispredicts, 16'd2);
    // Drive enough updates to saturate the branch counter.
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 5'd0; upd_ghr = 5'd0;
    upd_taken = 1'b0; upd_target = 5'd0; upd_mispredict = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    cmp("stat_branches_sat", stat_branches, 16'hFFFF);
    cmp("stat_mispredicts_hold", stat_mispredicts, 16'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
